nmx1_wb_initiator: RTL

- Wishbone classic slave to NEUROMORPHIC_X1 macro initiator bridge; sits between the SoC Wishbone bus and the 32x32 ReRAM macro.
- Converts single Wishbone read/write cycles into the macro's EN/R_WB/DI/AD/SEL request and waits for the macro's func_ack.
- Returns read data (DO) or a write acknowledge to the bus.
- A watchdog converts a missing macro acknowledge into a Wishbone error.

---
 rtl/nmx1_wb_initiator.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/nmx1_wb_initiator.sv
// Wishbone classic slave that drives one NEUROMORPHIC_X1 macro request at a time.
// Optional occupancy tracking is enabled by defining NMX1_OCCUPANCY_EN.
module nmx1_wb_initiator #(
  parameter int TO_CYCLES = 1024,
  parameter int TO_W      = 16
) (
  input  logic        CLKin,
  input  logic        RSTin,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        mac_en,
  output logic        mac_r_wb,
  output logic [31:0] mac_di,
  output logic [31:0] mac_ad,
  output logic [3:0]  mac_sel,
  input  logic [31:0] mac_do,
  input  logic        mac_ack,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, WR_PULSE, WR_WAIT, RD_HOLD, RESP, GAP} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);

  state_t          state_q, state_d;
  logic [TO_W-1:0] wd_q, wd_d;
  logic [31:0]     dat_q, dat_d, di_q, di_d, ad_q, ad_d;
  logic [3:0]      sel_q, sel_d;
  logic            ack_q, ack_d, err_q, err_d, en_q, en_d, rwb_q, rwb_d, busy_q, busy_d;
  logic            reject;

`ifdef NMX1_OCCUPANCY_EN
  logic [5:0] occ_q, occ_d;
  // Requests that cannot succeed (empty read / full write) are refused locally.
  assign reject = wb_we_i ? (occ_q == 6'd32) : (occ_q == 6'd0);
`else
  assign reject = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    dat_d   = dat_q;
    di_d    = di_q;
    ad_d    = ad_q;
    sel_d   = sel_q;
    en_d    = en_q;
    rwb_d   = rwb_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
`ifdef NMX1_OCCUPANCY_EN
    occ_d   = occ_q;
`endif
    case (state_q)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i && !ack_q && !err_q) begin
          wd_d = '0;
          if (reject) begin
            err_d   = 1'b1;
            dat_d   = '0;
            state_d = RESP;
          end else begin
            ad_d    = wb_adr_i;
            di_d    = wb_dat_i;
            sel_d   = wb_sel_i;
            en_d    = 1'b1;
            rwb_d   = !wb_we_i;
            state_d = wb_we_i ? WR_PULSE : RD_HOLD;
          end
        end
      end
      WR_PULSE: begin
        // The macro commits on every edge EN is high, so EN lasts one cycle only.
        en_d = 1'b0;
        if (mac_ack) begin
          ack_d   = 1'b1;
          state_d = RESP;
`ifdef NMX1_OCCUPANCY_EN
          occ_d   = occ_q + 6'd1;
`endif
        end else begin
          state_d = WR_WAIT;
        end
      end
      WR_WAIT: begin
        if (!wb_cyc_i) begin
          state_d = GAP;
        end else if (mac_ack) begin
          ack_d   = 1'b1;
          state_d = RESP;
`ifdef NMX1_OCCUPANCY_EN
          occ_d   = occ_q + 6'd1;
`endif
        end else if (wd_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      RD_HOLD: begin
        if (!wb_cyc_i) begin
          en_d    = 1'b0;
          state_d = GAP;
        end else if (mac_ack) begin
          dat_d   = mac_do;
          en_d    = 1'b0;
          ack_d   = 1'b1;
          state_d = RESP;
`ifdef NMX1_OCCUPANCY_EN
          occ_d   = occ_q - 6'd1;
`endif
        end else if (wd_q == TO_LAST) begin
          en_d    = 1'b0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      RESP:    state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLKin or negedge RSTin) begin
    if (!RSTin) begin
      state_q <= IDLE;
      wd_q    <= '0;
      dat_q   <= '0;
      di_q    <= '0;
      ad_q    <= '0;
      sel_q   <= '0;
      en_q    <= 1'b0;
      rwb_q   <= 1'b1;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef NMX1_OCCUPANCY_EN
      occ_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      dat_q   <= dat_d;
      di_q    <= di_d;
      ad_q    <= ad_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      rwb_q   <= rwb_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
`ifdef NMX1_OCCUPANCY_EN
      occ_q   <= occ_d;
`endif
    end
  end

  assign wb_dat_o = dat_q;
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign mac_en   = en_q;
  assign mac_r_wb = rwb_q;
  assign mac_di   = di_q;
  assign mac_ad   = ad_q;
  assign mac_sel  = sel_q;
  assign busy     = busy_q;

endmodule
